// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memories.
// Latency: none, wires only.
// Backpressure: carried by instr_valid / dmem_ready back to the controller.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             instr_valid;
  logic             dmem_ready;
  logic             br_flag;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             sel_A;
  logic             sel_B;
  logic [3:0]       ALUControl;
  logic [2:0]       funct3;
  logic             ir_we;
  logic             pc_we;
  logic             reg_we;
  logic [1:0]       pc_src;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  // Datapath / memory / bench side
  modport master (
    output instr, instr_valid, dmem_ready, br_flag,
    input  imem_req, dmem_req, dmem_we, sel_A, sel_B, ALUControl, funct3,
           ir_we, pc_we, reg_we, pc_src, wb_sel, illegal, state, instret
  );

  // Controller side
  modport slave (
    input  instr, instr_valid, dmem_ready, br_flag,
    output imem_req, dmem_req, dmem_we, sel_A, sel_B, ALUControl, funct3,
           ir_we, pc_we, reg_we, pc_src, wb_sel, illegal, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: branch 3 cycles, ALU/jump 4, store 4, load 5, plus memory wait states.
// Backpressure: imem_req held until instr_valid, dmem_req held until dmem_ready.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  state_t           state_q, state_d;
  logic             run_q;      // low only in the first cycle after reset release
  // Only the instruction fields the controller decodes are kept in the IR
  logic [6:0]       ir_op;
  logic [4:0]       ir_rd;
  logic [2:0]       ir_f3;
  logic             ir_f7b5;
  logic [CNT_W-1:0] instret_q;

  cls_t       cls;
  logic [3:0] alu_ctl;
  logic       sel_a, sel_b;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic [1:0] pc_src, wb_sel;

  // funct3-driven ALU op; SUB only exists in R-type, SRA/SRL chosen by funct7[5]
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Opcode class of the instruction held in the IR
  always_comb begin
    cls = C_NONE;
    case (ir_op)
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_I;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1100011: cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      default:    cls = C_NONE;
    endcase
  end

  // Operand selects and ALU op follow the IR, so they stay stable from DECODE to WB
  always_comb begin
    alu_ctl = ALU_ADD;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    case (cls)
      C_R:                       begin sel_a = 1'b1; sel_b = 1'b0; alu_ctl = f3_to_alu(ir_f3, ir_f7b5, 1'b1); end
      C_I:                       begin sel_a = 1'b1; sel_b = 1'b1; alu_ctl = f3_to_alu(ir_f3, ir_f7b5, 1'b0); end
      C_LOAD, C_STORE, C_JALR:   begin sel_a = 1'b1; sel_b = 1'b1; end
      C_BRANCH, C_JAL, C_AUIPC:  begin sel_a = 1'b0; sel_b = 1'b1; end
      C_LUI:                     begin sel_a = 1'b1; sel_b = 1'b1; alu_ctl = ALU_PASSB; end
      default:                   ;  // unsupported or reset IR: everything stays 0
    endcase
  end

  // Next state and per-state strobes
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    pc_src   = 2'd0;
    wb_sel   = 2'd0;
    case (state_q)
      FETCH: begin
        imem_req = run_q;
        if (run_q && bus.instr_valid) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = (cls == C_NONE) ? TRAP : EXEC;
      EXEC: begin
        if (cls == C_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = bus.br_flag ? 2'd1 : 2'd0;
          state_d = FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (bus.dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        pc_we   = 1'b1;
        reg_we  = (ir_rd != 5'd0);
        case (cls)
          C_JAL:   begin pc_src = 2'd1; wb_sel = 2'd2; end
          C_JALR:  begin pc_src = 2'd2; wb_sel = 2'd2; end
          C_LOAD:  begin pc_src = 2'd0; wb_sel = 2'd1; end
          default: begin pc_src = 2'd0; wb_sel = 2'd0; end
        endcase
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // State, IR and retirement counter; a return to FETCH from any other state retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      ir_op     <= 7'd0;
      ir_rd     <= 5'd0;
      ir_f3     <= 3'd0;
      ir_f7b5   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (ir_we) begin
        ir_op   <= bus.instr[6:0];
        ir_rd   <= bus.instr[11:7];
        ir_f3   <= bus.instr[14:12];
        ir_f7b5 <= bus.instr[30];
      end
      if (state_q != FETCH && state_d == FETCH)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_we      = ir_we;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.pc_we      = pc_we;
  assign bus.reg_we     = reg_we;
  assign bus.pc_src     = pc_src;
  assign bus.wb_sel     = wb_sel;
  assign bus.sel_A      = sel_a;
  assign bus.sel_B      = sel_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.funct3     = ir_f3;
  assign bus.illegal    = (state_q == TRAP);
  assign bus.state      = state_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-scenario tasks with inline expected values.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// A narrow counter width keeps the retirement wrap case short.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  localparam logic [31:0] I_ADD   = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h402081B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_BEQ   = 32'h00208463;  // beq  x1,x2,+8
  localparam logic [31:0] I_LW    = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] I_SW    = 32'h0020A023;  // sw   x2,0(x1)
  localparam logic [31:0] I_JALR1 = 32'h000280E7;  // jalr x1,0(x5)
  localparam logic [31:0] I_JALR0 = 32'h00028067;  // jalr x0,0(x5)
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  // Decode table: instr, ALUControl, sel_A, sel_B, WB pc_src, WB wb_sel
  localparam logic [31:0] T_INS [7] = '{32'h402081B3, 32'h0020C1B3, 32'h4020D193, 32'h0050F193,
                                        32'h12345237, 32'h010000EF, 32'h00001297};
  localparam logic [3:0]  T_ALU [7] = '{4'd1, 4'd5, 4'd7, 4'd9, 4'd10, 4'd0, 4'd0};
  localparam logic        T_SA  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic        T_SB  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [1:0]  T_PS  [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
  localparam logic [1:0]  T_WS  [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};

  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_ret;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();
  multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task test_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b1;
    bus.dmem_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if ({bus.illegal, bus.instret} !== '0) begin n_bad++; $display("FAIL reset_illegal_instret: got %0b/%0d want 0/0", bus.illegal, bus.instret); end
    n_cmp++; if ({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.reg_we} !== 6'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 000000", {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.reg_we}); end
    n_cmp++; if ({bus.sel_A, bus.sel_B, bus.ALUControl, bus.funct3, bus.pc_src, bus.wb_sel} !== 13'b0) begin n_bad++; $display("FAIL reset_selects: got %b want 0", {bus.sel_A, bus.sel_B, bus.ALUControl, bus.funct3, bus.pc_src, bus.wb_sel}); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    bus.dmem_ready  = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_release_same_cycle_imem_req: got %b want 0", bus.imem_req); end
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_first_imem_req: got %b want 1", bus.imem_req); end
    exp_ret = '0;
  endtask

  task test_add();
    n_cmp++; if (bus.ir_we !== 1'b0) begin n_bad++; $display("FAIL add_fetch_wait_ir_we: got %b want 0", bus.ir_we); end
    @(negedge clk); bus.instr = I_ADD; bus.instr_valid = 1'b1; #1;
    n_cmp++; if ({bus.state, bus.imem_req, bus.ir_we} !== {3'd0, 2'b11}) begin n_bad++; $display("FAIL add_fetch_hit: got st=%0d req=%b ir_we=%b want 0/1/1", bus.state, bus.imem_req, bus.ir_we); end
    // a response presented outside FETCH must be ignored
    @(negedge clk); bus.instr = I_SUB; #1;
    n_cmp++; if ({bus.state, bus.ir_we} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL add_decode_state: got st=%0d ir_we=%b want 1/0", bus.state, bus.ir_we); end
    n_cmp++; if ({bus.ALUControl, bus.sel_A, bus.sel_B} !== {4'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL add_decode_ctl: got alu=%0d a=%b b=%b want 0/1/0", bus.ALUControl, bus.sel_A, bus.sel_B); end
    @(negedge clk); bus.instr_valid = 1'b0; #1;
    n_cmp++; if ({bus.state, bus.ALUControl, bus.pc_we, bus.reg_we} !== {3'd2, 4'd0, 2'b00}) begin n_bad++; $display("FAIL add_exec: got st=%0d alu=%0d pc_we=%b reg_we=%b want 2/0/0/0", bus.state, bus.ALUControl, bus.pc_we, bus.reg_we); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.state, bus.reg_we, bus.pc_we, bus.pc_src, bus.wb_sel} !== {3'd4, 2'b11, 2'd0, 2'd0}) begin n_bad++; $display("FAIL add_wb: got st=%0d reg_we=%b pc_we=%b ps=%0d ws=%0d want 4/1/1/0/0", bus.state, bus.reg_we, bus.pc_we, bus.pc_src, bus.wb_sel); end
    @(negedge clk); #1; exp_ret = exp_ret + 1'b1;
    n_cmp++; if ({bus.state, bus.instret, bus.reg_we, bus.pc_we} !== {3'd0, exp_ret, 2'b00}) begin n_bad++; $display("FAIL add_retire: got st=%0d instret=%0d want 0/%0d", bus.state, bus.instret, exp_ret); end
  endtask

  task test_branch();
    for (int k = 0; k < 2; k++) begin
      bus.instr = I_BEQ; bus.instr_valid = 1'b1; #1;
      @(negedge clk); bus.instr_valid = 1'b0; bus.br_flag = (k == 0); #1;
      n_cmp++; if ({bus.state, bus.sel_A, bus.sel_B, bus.ALUControl, bus.funct3} !== {3'd1, 1'b0, 1'b1, 4'd0, 3'd0}) begin n_bad++; $display("FAIL beq_decode_%0d: got st=%0d a=%b b=%b alu=%0d f3=%0d", k, bus.state, bus.sel_A, bus.sel_B, bus.ALUControl, bus.funct3); end
      @(negedge clk); #1;
      n_cmp++; if ({bus.state, bus.pc_we, bus.pc_src, bus.reg_we} !== {3'd2, 1'b1, (k == 0) ? 2'd1 : 2'd0, 1'b0}) begin n_bad++; $display("FAIL beq_exec_%0d: got st=%0d pc_we=%b ps=%0d reg_we=%b", k, bus.state, bus.pc_we, bus.pc_src, bus.reg_we); end
      @(negedge clk); bus.br_flag = 1'b0; #1; exp_ret = exp_ret + 1'b1;
      n_cmp++; if ({bus.state, bus.instret, bus.pc_we} !== {3'd0, exp_ret, 1'b0}) begin n_bad++; $display("FAIL beq_retire_%0d: got st=%0d instret=%0d want 0/%0d", k, bus.state, bus.instret, exp_ret); end
    end
  endtask

  task test_load();
    bus.instr = I_LW; bus.instr_valid = 1'b1; #1;
    @(negedge clk); bus.instr_valid = 1'b0; bus.dmem_ready = 1'b1; #1;
    n_cmp++; if ({bus.state, bus.funct3, bus.sel_A, bus.sel_B, bus.ALUControl, bus.dmem_req} !== {3'd1, 3'd2, 2'b11, 4'd0, 1'b0}) begin n_bad++; $display("FAIL lw_decode: got st=%0d f3=%0d a=%b b=%b alu=%0d dreq=%b", bus.state, bus.funct3, bus.sel_A, bus.sel_B, bus.ALUControl, bus.dmem_req); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.state, bus.dmem_req} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL lw_exec: got st=%0d dreq=%b want 2/0", bus.state, bus.dmem_req); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); bus.dmem_ready = (c == 3); #1;
      n_cmp++; if ({bus.state, bus.dmem_req, bus.dmem_we, bus.pc_we} !== {3'd3, 3'b100}) begin n_bad++; $display("FAIL lw_mem_%0d: got st=%0d dreq=%b dwe=%b pc_we=%b want 3/1/0/0", c, bus.state, bus.dmem_req, bus.dmem_we, bus.pc_we); end
    end
    @(negedge clk); bus.dmem_ready = 1'b0; #1;
    n_cmp++; if ({bus.state, bus.wb_sel, bus.pc_src, bus.reg_we, bus.pc_we, bus.dmem_req} !== {3'd4, 2'd1, 2'd0, 3'b110}) begin n_bad++; $display("FAIL lw_wb: got st=%0d ws=%0d ps=%0d reg_we=%b pc_we=%b dreq=%b", bus.state, bus.wb_sel, bus.pc_src, bus.reg_we, bus.pc_we, bus.dmem_req); end
    @(negedge clk); #1; exp_ret = exp_ret + 1'b1;
    n_cmp++; if ({bus.state, bus.instret} !== {3'd0, exp_ret}) begin n_bad++; $display("FAIL lw_retire: got st=%0d instret=%0d want 0/%0d", bus.state, bus.instret, exp_ret); end
  endtask

  task test_jalr();
    for (int k = 0; k < 2; k++) begin
      bus.instr = (k == 0) ? I_JALR1 : I_JALR0; bus.instr_valid = 1'b1; #1;
      @(negedge clk); bus.instr_valid = 1'b0; #1;
      n_cmp++; if ({bus.state, bus.sel_A, bus.sel_B, bus.ALUControl} !== {3'd1, 2'b11, 4'd0}) begin n_bad++; $display("FAIL jalr_decode_%0d: got st=%0d a=%b b=%b alu=%0d", k, bus.state, bus.sel_A, bus.sel_B, bus.ALUControl); end
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_cmp++; if ({bus.state, bus.pc_src, bus.wb_sel, bus.pc_we, bus.reg_we} !== {3'd4, 2'd2, 2'd2, 1'b1, (k == 0)}) begin n_bad++; $display("FAIL jalr_wb_%0d: got st=%0d ps=%0d ws=%0d pc_we=%b reg_we=%b", k, bus.state, bus.pc_src, bus.wb_sel, bus.pc_we, bus.reg_we); end
      @(negedge clk); #1; exp_ret = exp_ret + 1'b1;
      n_cmp++; if ({bus.state, bus.instret} !== {3'd0, exp_ret}) begin n_bad++; $display("FAIL jalr_retire_%0d: got st=%0d instret=%0d want 0/%0d", k, bus.state, bus.instret, exp_ret); end
    end
  endtask

  task test_decode();
    for (int t = 0; t < 7; t++) begin
      bus.instr = T_INS[t]; bus.instr_valid = 1'b1; #1;
      @(negedge clk); bus.instr_valid = 1'b0; #1;
      n_cmp++; if ({bus.ALUControl, bus.sel_A, bus.sel_B} !== {T_ALU[t], T_SA[t], T_SB[t]}) begin n_bad++; $display("FAIL decode_%0d: got alu=%0d a=%b b=%b want %0d/%b/%b", t, bus.ALUControl, bus.sel_A, bus.sel_B, T_ALU[t], T_SA[t], T_SB[t]); end
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_cmp++; if ({bus.state, bus.ALUControl, bus.pc_src, bus.wb_sel, bus.reg_we, bus.pc_we} !== {3'd4, T_ALU[t], T_PS[t], T_WS[t], 2'b11}) begin n_bad++; $display("FAIL decode_wb_%0d: got st=%0d alu=%0d ps=%0d ws=%0d reg_we=%b pc_we=%b", t, bus.state, bus.ALUControl, bus.pc_src, bus.wb_sel, bus.reg_we, bus.pc_we); end
      @(negedge clk); #1; exp_ret = exp_ret + 1'b1;
    end
    n_cmp++; if (bus.instret !== exp_ret) begin n_bad++; $display("FAIL decode_instret: got %0d want %0d", bus.instret, exp_ret); end
  endtask

  task test_store_abort();
    // completed store
    bus.instr = I_SW; bus.instr_valid = 1'b1; #1;
    @(negedge clk); bus.instr_valid = 1'b0; #1;
    n_cmp++; if ({bus.state, bus.funct3, bus.sel_A, bus.sel_B} !== {3'd1, 3'd2, 2'b11}) begin n_bad++; $display("FAIL sw_decode: got st=%0d f3=%0d a=%b b=%b", bus.state, bus.funct3, bus.sel_A, bus.sel_B); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_cmp++; if ({bus.state, bus.dmem_req, bus.dmem_we, bus.pc_we} !== {3'd3, 3'b110}) begin n_bad++; $display("FAIL sw_mem_wait: got st=%0d dreq=%b dwe=%b pc_we=%b want 3/1/1/0", bus.state, bus.dmem_req, bus.dmem_we, bus.pc_we); end
    @(negedge clk); bus.dmem_ready = 1'b1; #1;
    n_cmp++; if ({bus.dmem_we, bus.pc_we, bus.pc_src, bus.reg_we} !== {2'b11, 2'd0, 1'b0}) begin n_bad++; $display("FAIL sw_mem_done: got dwe=%b pc_we=%b ps=%0d reg_we=%b want 1/1/0/0", bus.dmem_we, bus.pc_we, bus.pc_src, bus.reg_we); end
    @(negedge clk); bus.dmem_ready = 1'b0; #1; exp_ret = exp_ret + 1'b1;
    n_cmp++; if ({bus.state, bus.instret, bus.pc_we} !== {3'd0, exp_ret, 1'b0}) begin n_bad++; $display("FAIL sw_retire: got st=%0d instret=%0d want 0/%0d", bus.state, bus.instret, exp_ret); end
    // second store aborted by reset while in MEM
    bus.instr_valid = 1'b1; #1;
    @(negedge clk); bus.instr_valid = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_cmp++; if ({bus.state, bus.dmem_we} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL sw2_mem: got st=%0d dwe=%b want 3/1", bus.state, bus.dmem_we); end
    @(negedge clk); bus.dmem_ready = 1'b1; rst_n = 1'b0; #1;
    n_cmp++; if ({bus.state, bus.dmem_req, bus.dmem_we, bus.pc_we, bus.reg_we, bus.instret} !== {3'd0, 4'b0000, {CW{1'b0}}}) begin n_bad++; $display("FAIL sw2_abort: got st=%0d dreq=%b dwe=%b pc_we=%b instret=%0d", bus.state, bus.dmem_req, bus.dmem_we, bus.pc_we, bus.instret); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.state, bus.dmem_req, bus.pc_we, bus.imem_req} !== {3'd0, 3'b000}) begin n_bad++; $display("FAIL sw2_abort_hold: got st=%0d dreq=%b pc_we=%b ireq=%b", bus.state, bus.dmem_req, bus.pc_we, bus.imem_req); end
    @(negedge clk); rst_n = 1'b1; bus.dmem_ready = 1'b0; #1;
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL sw2_restart_imem_req: got %b want 1", bus.imem_req); end
    exp_ret = '0;
  endtask

  task test_wrap();
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      bus.instr = I_BEQ; bus.instr_valid = 1'b1;
      @(negedge clk); bus.instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
    end
    n_cmp++; if (bus.instret !== {CW{1'b1}}) begin n_bad++; $display("FAIL wrap_all_ones: got %0d want %0d", bus.instret, {CW{1'b1}}); end
    bus.instr_valid = 1'b1;
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (bus.instret !== {CW{1'b0}}) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", bus.instret); end
  endtask

  task test_illegal();
    bus.instr = I_ILL; bus.instr_valid = 1'b1; #1;
    @(negedge clk); bus.instr_valid = 1'b0; #1;
    n_cmp++; if ({bus.state, bus.sel_A, bus.sel_B, bus.ALUControl} !== {3'd1, 6'b0}) begin n_bad++; $display("FAIL ill_decode: got st=%0d a=%b b=%b alu=%0d", bus.state, bus.sel_A, bus.sel_B, bus.ALUControl); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); bus.instr = I_ADD; bus.instr_valid = 1'b1; bus.dmem_ready = 1'b1; #1;
      n_cmp++; if ({bus.state, bus.illegal, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.reg_we} !== {3'd5, 1'b1, 6'b0}) begin n_bad++; $display("FAIL ill_trap_%0d: got st=%0d ill=%b strobes=%b", c, bus.state, bus.illegal, {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.reg_we}); end
    end
    @(negedge clk); rst_n = 1'b0; bus.instr_valid = 1'b0; bus.dmem_ready = 1'b0; #1;
    n_cmp++; if ({bus.state, bus.illegal} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL ill_reset_clear: got st=%0d ill=%b want 0/0", bus.state, bus.illegal); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({bus.state, bus.illegal, bus.imem_req} !== {3'd0, 2'b01}) begin n_bad++; $display("FAIL ill_restart: got st=%0d ill=%b ireq=%b want 0/0/1", bus.state, bus.illegal, bus.imem_req); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instr = 32'd0;
    bus.instr_valid = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_flag = 1'b0;
    exp_ret = '0;
    test_reset();
    test_add();
    test_branch();
    test_load();
    test_jalr();
    test_decode();
    test_store_abort();
    test_wrap();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port instr, input, 32 bits: instruction word from instruction memory, valid with instr_valid.
REQ-005 The block SHALL have port instr_valid, input, 1 bit: instruction memory response strobe.
REQ-006 The block SHALL have port dmem_ready, input, 1 bit: data memory access complete.
REQ-007 The block SHALL have port br_flag, input, 1 bit: branch condition from the execute stage.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-009 The block SHALL have ports dmem_req and dmem_we, outputs, 1 bit each: data access request and write enable.
REQ-010 The block SHALL have ports sel_A and sel_B, outputs, 1 bit each: operand selects (sel_A 0=PC, 1=rdata1; sel_B 0=rdata2, 1=ImmExt).
REQ-011 The block SHALL have ports ALUControl (4 bits) and funct3 (3 bits), outputs: ALU operation and branch condition code.
REQ-012 The block SHALL have outputs ir_we, pc_we and reg_we, 1 bit each: instruction register, PC and register-file write strobes.
REQ-013 The block SHALL have outputs pc_src (2 bits: 0=PC+4, 1=ALUResult, 2=ALUResult with bit0 cleared) and wb_sel (2 bits: 0=ALU, 1=memory, 2=PC+4).
REQ-014 The block SHALL have outputs illegal (1 bit), state (3 bits) and instret (CNT_W bits).

Function
REQ-015 The FSM SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, and SHALL decode the IR opcode classes R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC.
REQ-016 In FETCH the block SHALL hold imem_req=1 until instr_valid=1; on that cycle it SHALL pulse ir_we=1, latch instr into the internal IR and go to DECODE.
REQ-017 DECODE SHALL last exactly 1 cycle and then go to EXEC, or to TRAP if the opcode is unsupported.
REQ-018 ALUControl encoding SHALL be 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
REQ-019 ALUControl SHALL be derived from funct3/funct7[5] for R-type; SUB only for R-type, SRA when funct7[5]=1.
REQ-020 LOAD, STORE, JALR, AUIPC, JAL and BRANCH SHALL use ADD; LUI SHALL use PASSB.
REQ-021 sel_A SHALL be 0 for AUIPC, JAL and BRANCH, and 1 otherwise.
REQ-022 sel_B SHALL be 0 for R-type only, and 1 otherwise.
REQ-023 sel_A, sel_B, ALUControl and funct3 SHALL hold stable from DECODE through WB.
REQ-024 In EXEC, BRANCH SHALL pulse pc_we with pc_src=1 if br_flag=1, else pc_src=0, then go to FETCH.
REQ-025 In EXEC, LOAD and STORE SHALL go to MEM; all other classes SHALL go to WB.
REQ-026 In MEM the block SHALL hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ready=1. STORE SHALL then pulse pc_we with pc_src=0 and go to FETCH; LOAD SHALL go to WB.
REQ-027 WB SHALL last 1 cycle with reg_we=1 and pc_we=1.
REQ-028 WB select encodings: JAL uses pc_src=1, wb_sel=2; JALR uses pc_src=2, wb_sel=2; LOAD uses pc_src=0, wb_sel=1; all others use pc_src=0, wb_sel=0. After WB the FSM SHALL go to FETCH.
REQ-029 reg_we SHALL be forced to 0 when IR rd=0.
REQ-030 instret SHALL increment by 1 on every transition into FETCH from a completed instruction, wrapping from all-ones to 0.
REQ-031 TRAP SHALL be absorbing: illegal=1, all strobes and requests 0, exited only by reset.
REQ-032 instr_valid outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-033 Every write strobe (ir_we, pc_we, reg_we) SHALL be a single-cycle pulse per instruction.

Reset
REQ-034 While rst_n=0 the block SHALL hold state=FETCH, IR=0, instret=0, illegal=0, and all request/strobe outputs and selects 0, regardless of clk.
REQ-035 Asserting rst_n mid-instruction SHALL abort that instruction with no pc_we, reg_we or dmem_req pulse.
REQ-036 The first imem_req SHALL assert on the cycle after rst_n deasserts.

Verification
REQ-037 ADD x3,x1,x2 (0x002081B3) with instr_valid on cycle 2 -> ALUControl=0, sel_A=1, sel_B=0, reg_we=1 in WB, instret=1, total 5 cycles.
REQ-038 BEQ with br_flag=1 -> pc_we=1, pc_src=1 in EXEC, no reg_we; with br_flag=0 -> pc_src=0.
REQ-039 LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then WB with wb_sel=1.
REQ-040 JALR x1,0(x5) -> WB with pc_src=2, wb_sel=2, reg_we=1; rd=x0 variant -> reg_we=0.
REQ-041 Opcode 0x7F -> state=TRAP, illegal=1 permanently; rst_n pulse clears it.
REQ-042 rst_n asserted during MEM of a store -> no dmem_we or pc_we pulse; instret preloaded to all-ones plus one retirement -> instret=0.
